// File: rtl/q_update_unit_pkg.sv
// Shared Q8.8 format constants, FSM state encoding and default tuning for the Q-update datapath.
package q_update_unit_pkg;

    localparam int          DATA_W          = 16;
    localparam int          FRAC_W          = 8;
    localparam logic [15:0] Q_MAX_POS       = 16'h7FFF;
    localparam logic [15:0] Q_MIN_NEG       = 16'h8000;
    localparam logic [7:0]  DEF_GAMMA       = 8'd128;
    localparam int          DEF_ALPHA_SHIFT = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/q_sat_trunc.sv
// Narrows the 18-bit signed Bellman sum to Q8.8; combinational, no latency, no handshake.
// Q_UPDATE_SAT_EN selects clamping to [0x8000, 0x7FFF]; otherwise two's-complement wrap.
module q_sat_trunc
    import q_update_unit_pkg::*;
(
    input  logic signed [DATA_W+1:0] i_val,
    output logic        [DATA_W-1:0] o_val
);

`ifdef Q_UPDATE_SAT_EN
    localparam logic signed [DATA_W+1:0] LIM_HI = {2'b00, Q_MAX_POS};
    localparam logic signed [DATA_W+1:0] LIM_LO = {2'b11, Q_MIN_NEG};

    always_comb begin
        o_val = i_val[DATA_W-1:0];
        if (i_val > LIM_HI) begin
            o_val = Q_MAX_POS;
        end else if (i_val < LIM_LO) begin
            o_val = Q_MIN_NEG;
        end
    end
`else
    logic [1:0] w_unused_hi;

    assign o_val       = i_val[DATA_W-1:0];
    assign w_unused_hi = i_val[DATA_W+1:DATA_W];
`endif

endmodule

// File: rtl/q_update_unit.sv
// Bellman Q update, one (state, action) per transaction: Q_new = Q_old + alpha*(R + gamma*Q_max - Q_old).
// 4-state FSM; out_valid 3 cycles after accept, in_ready low until the result handshake.
// Result held stable under out_ready backpressure; Q_UPDATE_SAT_EN enables result saturation.
module q_update_unit
    import q_update_unit_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter int         ADDR_W      = 8,
    parameter logic [7:0] GAMMA       = DEF_GAMMA,
    parameter int         ALPHA_SHIFT = DEF_ALPHA_SHIFT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] q_old,
    input  logic [DATA_W-1:0] q_max,
    input  logic [DATA_W-1:0] reward,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] q_new,
    output logic [15:0]       upd_count
);

    localparam int ACC_W  = DATA_W + 2;
    localparam int PROD_W = DATA_W + FRAC_W;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_q_old;
    logic [DATA_W-1:0]   r_q_max;
    logic [DATA_W-1:0]   r_reward;
    logic [DATA_W-1:0]   r_prod;
    logic [DATA_W-1:0]   r_q_new;
    logic [15:0]         r_upd_count;

    logic signed [PROD_W-1:0] w_prod_full;
    logic        [FRAC_W-1:0] w_unused_prod_lsb;
    logic signed [ACC_W-1:0]  w_q_old_ext;
    logic signed [ACC_W-1:0]  w_td;
    logic signed [ACC_W-1:0]  w_sum;
    logic        [DATA_W-1:0] w_q_new;

    // GAMMA is unsigned Q0.8, so it is zero-extended before the signed multiply.
    assign w_prod_full = $signed({{FRAC_W{r_q_max[DATA_W-1]}}, r_q_max})
                       * $signed({{DATA_W{1'b0}}, GAMMA});
    assign w_unused_prod_lsb = w_prod_full[FRAC_W-1:0];

    assign w_q_old_ext = $signed({{2{r_q_old[DATA_W-1]}}, r_q_old});
    assign w_td        = $signed({{2{r_reward[DATA_W-1]}}, r_reward})
                       + $signed({{2{r_prod[DATA_W-1]}}, r_prod})
                       - w_q_old_ext;
    assign w_sum       = w_q_old_ext + (w_td >>> ALPHA_SHIFT);

    q_sat_trunc u_sat_trunc (
        .i_val (w_sum),
        .o_val (w_q_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_addr      <= '0;
            r_q_old     <= '0;
            r_q_max     <= '0;
            r_reward    <= '0;
            r_prod      <= '0;
            r_q_new     <= '0;
            r_upd_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_addr     <= in_addr;
                        r_q_old    <= q_old;
                        r_q_max    <= q_max;
                        r_reward   <= reward;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_prod  <= w_prod_full[FRAC_W +: DATA_W];
                    r_state <= ST_ACC;
                end
                ST_ACC: begin
                    r_q_new     <= w_q_new;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_upd_count <= r_upd_count + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_addr  = r_addr;
    assign q_new     = r_q_new;
    assign upd_count = r_upd_count;

endmodule

// File: tb/tb_q_update_unit.sv
// Directed self-checking bench for q_update_unit; a second instance runs with GAMMA=255 for the overflow case.
module tb_q_update_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        in_valid2 = 1'b0;
    logic        out_ready2 = 1'b0;
    logic [7:0]  in_addr = 8'h00;
    logic [15:0] q_old = 16'h0000;
    logic [15:0] q_max = 16'h0000;
    logic [15:0] reward = 16'h0000;

    logic        in_ready, out_valid, in_ready2, out_valid2;
    logic [7:0]  out_addr, out_addr2;
    logic [15:0] q_new, q_new2, upd_count, upd_count2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit          mon_en = 1'b0;
    logic [15:0] res_q[$];
    logic [7:0]  addr_q[$];

`ifdef Q_UPDATE_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h7FFF;
`else
    localparam logic [15:0] OVF_EXP = 16'h9EDF;
`endif

    q_update_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_addr   (in_addr),
        .q_old     (q_old),
        .q_max     (q_max),
        .reward    (reward),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .q_new     (q_new),
        .upd_count (upd_count)
    );

    q_update_unit #(.GAMMA(8'd255)) dut_g255 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .in_addr   (in_addr),
        .q_old     (q_old),
        .q_max     (q_max),
        .reward    (reward),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .out_addr  (out_addr2),
        .q_new     (q_new2),
        .upd_count (upd_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            res_q.push_back(q_new);
            addr_q.push_back(out_addr);
        end
    end

    task automatic set_vec(input logic [7:0] a, input logic [15:0] qo, input logic [15:0] qm,
                           input logic [15:0] rw);
        in_addr = a;
        q_old   = qo;
        q_max   = qm;
        reward  = rw;
    endtask

    task automatic apply_reset;
        in_valid   = 1'b0;
        in_valid2  = 1'b0;
        out_ready  = 1'b0;
        out_ready2 = 1'b0;
        rst_n      = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents the current vector until accepted; returns at #1 after the accept edge.
    task automatic send(output bit ok);
        ok = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Counts edges from the accept edge (inclusive) until out_valid is seen.
    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_addr !== 8'h00) begin errors++; $display("FAIL reset_out_addr: got %h expected 00", out_addr); end
        checks++; if (q_new !== 16'h0000) begin errors++; $display("FAIL reset_q_new: got %h expected 0000", q_new); end
        checks++; if (upd_count !== 16'h0000) begin errors++; $display("FAIL reset_upd_count: got %h expected 0000", upd_count); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        bit ok;
        int n;
        out_ready = 1'b1;
        set_vec(8'hA5, 16'h0100, 16'h0200, 16'h0100);
        send(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", ok); end
        wait_out(n);
        checks++; if (n != 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", n); end
        checks++; if (q_new !== 16'h0140) begin errors++; $display("FAIL basic_q_new: got %h expected 0140", q_new); end
        checks++; if (out_addr !== 8'hA5) begin errors++; $display("FAIL basic_out_addr: got %h expected a5", out_addr); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_busy: got %b expected 0", in_ready); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_out_valid_drop: got %b expected 0", out_valid); end
        checks++; if (upd_count !== 16'd1) begin errors++; $display("FAIL basic_upd_count: got %0d expected 1", upd_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
    endtask

    task automatic test_negative_td;
        bit ok;
        int n;
        out_ready = 1'b1;
        set_vec(8'h5A, 16'h0300, 16'h0000, 16'hFF00);
        send(ok);
        wait_out(n);
        checks++; if (n != 3) begin errors++; $display("FAIL neg_latency: got %0d expected 3", n); end
        checks++; if (q_new !== 16'h0200) begin errors++; $display("FAIL neg_q_new: got %h expected 0200", q_new); end
        checks++; if (out_addr !== 8'h5A) begin errors++; $display("FAIL neg_out_addr: got %h expected 5a", out_addr); end
        @(posedge clk);
        #1;
        checks++; if (upd_count !== 16'd2) begin errors++; $display("FAIL neg_upd_count: got %0d expected 2", upd_count); end
    endtask

    task automatic test_overflow;
        int n;
        out_ready2 = 1'b1;
        set_vec(8'h77, 16'h7F00, 16'h7FFF, 16'h7F00);
        in_valid2 = 1'b1;
        @(posedge clk);
        #1 in_valid2 = 1'b0;
        n = 1;
        while (!out_valid2 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++; if (n != 3) begin errors++; $display("FAIL ovf_latency: got %0d expected 3", n); end
        checks++; if (q_new2 !== OVF_EXP) begin errors++; $display("FAIL ovf_q_new: got %h expected %h", q_new2, OVF_EXP); end
        checks++; if (out_addr2 !== 8'h77) begin errors++; $display("FAIL ovf_out_addr: got %h expected 77", out_addr2); end
        @(posedge clk);
        #1;
        checks++; if (upd_count2 !== 16'd1) begin errors++; $display("FAIL ovf_upd_count: got %0d expected 1", upd_count2); end
        checks++; if (upd_count !== 16'd2) begin errors++; $display("FAIL ovf_main_untouched: got %0d expected 2", upd_count); end
    endtask

    task automatic test_backpressure;
        bit ok;
        int n;
        out_ready = 1'b0;
        set_vec(8'h33, 16'h0300, 16'h0000, 16'hFF00);
        send(ok);
        wait_out(n);
        checks++; if (n != 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", n); end
        set_vec(8'h44, 16'h0100, 16'h0200, 16'h0100);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid_hold[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (q_new !== 16'h0200) begin errors++; $display("FAIL bp_q_new_stable[%0d]: got %h expected 0200", i, q_new); end
            checks++; if (out_addr !== 8'h33) begin errors++; $display("FAIL bp_addr_stable[%0d]: got %h expected 33", i, out_addr); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low[%0d]: got %b expected 0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %b expected 1", in_ready); end
        checks++; if (upd_count !== 16'd3) begin errors++; $display("FAIL bp_upd_count: got %0d expected 3", upd_count); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept: got %b expected 0", in_ready); end
        wait_out(n);
        checks++; if (n != 3) begin errors++; $display("FAIL bp_second_latency: got %0d expected 3", n); end
        checks++; if (q_new !== 16'h0140) begin errors++; $display("FAIL bp_second_q_new: got %h expected 0140", q_new); end
        checks++; if (out_addr !== 8'h44) begin errors++; $display("FAIL bp_second_addr: got %h expected 44", out_addr); end
        @(posedge clk);
        #1;
        checks++; if (upd_count !== 16'd4) begin errors++; $display("FAIL bp_second_count: got %0d expected 4", upd_count); end
    endtask

    task automatic test_reset_mid_op;
        bit ok;
        int n;
        out_ready = 1'b1;
        set_vec(8'h21, 16'h0100, 16'h0200, 16'h0100);
        send(ok);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        checks++; if (upd_count !== 16'd0) begin errors++; $display("FAIL midrst_upd_count: got %0d expected 0", upd_count); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_vec(8'h22, 16'h0100, 16'h0200, 16'h0100);
        send(ok);
        wait_out(n);
        checks++; if (n != 3) begin errors++; $display("FAIL midrst_next_latency: got %0d expected 3", n); end
        checks++; if (q_new !== 16'h0140) begin errors++; $display("FAIL midrst_next_q_new: got %h expected 0140", q_new); end
        checks++; if (out_addr !== 8'h22) begin errors++; $display("FAIL midrst_next_addr: got %h expected 22", out_addr); end
        @(posedge clk);
        #1;
        checks++; if (upd_count !== 16'd1) begin errors++; $display("FAIL midrst_next_count: got %0d expected 1", upd_count); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  va[3]  = '{8'h10, 8'h11, 8'h12};
        logic [15:0] vqo[3] = '{16'h0100, 16'h0300, 16'h0000};
        logic [15:0] vqm[3] = '{16'h0200, 16'h0000, 16'h0100};
        logic [15:0] vrw[3] = '{16'h0100, 16'hFF00, 16'h0080};
        logic [15:0] vexp[3] = '{16'h0140, 16'h0200, 16'h0040};
        int acc[3];
        int t;
        apply_reset();
        res_q.delete();
        addr_q.delete();
        mon_en = 1'b1;
        out_ready = 1'b1;
        set_vec(va[0], vqo[0], vqm[0], vrw[0]);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            t = 0;
            while (!in_ready && t < 20) begin
                @(posedge clk);
                #1;
                t++;
            end
            @(posedge clk);
            #1 acc[k] = cyc;
            if (k < 2) set_vec(va[k+1], vqo[k+1], vqm[k+1], vrw[k+1]);
            else in_valid = 1'b0;
        end
        t = 0;
        while (res_q.size() < 3 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        mon_en = 1'b0;
        checks++; if (acc[1] - acc[0] != 4) begin errors++; $display("FAIL b2b_spacing_01: got %0d expected 4", acc[1] - acc[0]); end
        checks++; if (acc[2] - acc[1] != 4) begin errors++; $display("FAIL b2b_spacing_12: got %0d expected 4", acc[2] - acc[1]); end
        checks++;
        if (res_q.size() != 3) begin
            errors++;
            $display("FAIL b2b_result_count: got %0d expected 3", res_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++; if (res_q[k] !== vexp[k]) begin errors++; $display("FAIL b2b_q_new[%0d]: got %h expected %h", k, res_q[k], vexp[k]); end
                checks++; if (addr_q[k] !== va[k]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", k, addr_q[k], va[k]); end
            end
        end
        checks++; if (upd_count !== 16'd3) begin errors++; $display("FAIL b2b_upd_count: got %0d expected 3", upd_count); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative_td();
        test_overflow();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
